serial_magnitude_comparator: RTL
================================

Name: serial_magnitude_comparator

Overview:
- Multi-bit magnitude comparator that walks two WIDTH-bit operands one bit per clock, MSB first.
- Each cycle it evaluates the per-bit less-than / greater-than / equal relation and resolves the word result at the first differing bit.
- Sits behind a valid/ready input handshake and a valid/ready result handshake, as the sequential consumer of per-bit comparison results.

Parameters:
- WIDTH, 8: operand width in bits; legal range 1..32.
- EARLY_EXIT, 1: 1 = finish at the first differing bit; 0 = always scan all WIDTH bits (constant latency).

Ports:
- i_w_clk  input  1  clock; all state changes on the rising edge.
- i_w_rst_n  input  1  asynchronous, active-low reset.
- i_w_valid  input  1  operand pair present.
- o_w_ready  output  1  block can accept operands.
- i_w_a  input  WIDTH  operand A (unsigned).
- i_w_b  input  WIDTH  operand B (unsigned).
- o_w_valid  output  1  result present.
- i_w_ready  input  1  downstream accepts result.
- o_w_lt  output  1  A < B.
- o_w_gt  output  1  A > B.
- o_w_eq  output  1  A == B.
- o_w_busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous assert, synchronous-to-clock deassert assumed externally):
  - state = IDLE; o_w_valid, o_w_lt, o_w_gt, o_w_eq, o_w_busy = 0; o_w_ready = 1.
  - Reset during SHIFT or DONE aborts the operation immediately; the partial result is discarded.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - o_w_ready = 1.
  - On an edge with i_w_valid & o_w_ready: capture i_w_a / i_w_b into shift registers, set bit counter = WIDTH-1, clear the sticky result, go to SHIFT.
  - i_w_a / i_w_b are sampled only on this accept edge.
- SHIFT:
  - o_w_ready = 0.
  - Each cycle, examine the MSB of both shift registers:
    - bit_lt = ~a & b
    - bit_gt = a & ~b
    - bit_eq = ~(a ^ b)
  - First cycle with bit_lt or bit_gt set: latch lt or gt into the sticky result. Later bits never overwrite it.
  - EARLY_EXIT=1: go to DONE on that edge.
  - Otherwise, shift both registers left by 1 and decrement the counter.
  - When counter == 0 is examined, go to DONE. If no difference was latched, the result is eq.
- DONE:
  - o_w_valid = 1; exactly one of o_w_lt / o_w_gt / o_w_eq is high.
  - The result holds stable while i_w_ready = 0.
  - On an edge with i_w_ready = 1: go to IDLE. o_w_ready is 1 on the following cycle; no same-cycle re-accept.
  - i_w_valid is ignored in DONE and SHIFT.
- Result outputs are 0 whenever o_w_valid = 0; they never glitch high outside DONE.
- Latency, counting accept edge = E0 and taking the first differing bit at index k:
  - EARLY_EXIT=1: o_w_valid rises after edge E(WIDTH-k).
  - Equal operands: E(WIDTH) in both modes.
  - EARLY_EXIT=0: always E(WIDTH).
- WIDTH = 1: SHIFT lasts exactly one cycle.
- Throughput: one comparison per (latency + 2) cycles minimum, with no back-to-back overlap.

Test Plan:
- WIDTH=8, EARLY_EXIT=1, A=0xA5, B=0xA5 -> o_w_valid after 8 edges, eq=1, lt=gt=0; o_w_ready=0 throughout SHIFT/DONE.
- A=0x80, B=0x7F -> gt=1 with o_w_valid after edge E1; A=0x12, B=0x13 -> lt=1 after E8.
- EARLY_EXIT=0, A=0x80, B=0x00 -> gt=1 only after E8. Check that the later equal bits do not change the sticky result.
- Backpressure: A=0x01, B=0xFF, hold i_w_ready=0 for 5 cycles in DONE while toggling i_w_valid and the operands -> lt=1 held stable, nothing accepted. Raise i_w_ready -> IDLE; the next pair A=0xFF, B=0x01 gives gt=1.
- Assert i_w_rst_n=0 mid-SHIFT (cycle 3 of a 0x0F vs 0x0E compare) -> all outputs 0 and o_w_ready=1 asynchronously. After release, compare 0x33 vs 0x33 -> eq=1 after E8.
- WIDTH=1 build: exhaustive (0,0)=eq, (0,1)=lt, (1,0)=gt, (1,1)=eq, each with valid after E1.

Source files
------------

// File: rtl/serial_magnitude_comparator_if.sv
// rtl/serial_magnitude_comparator_if.sv - operand/result handshake bundle for the serial comparator
interface serial_magnitude_comparator_if #(
   parameter int WIDTH = 8
);
   logic             i_w_valid;
   logic             o_w_ready;
   logic [WIDTH-1:0] i_w_a;
   logic [WIDTH-1:0] i_w_b;
   logic             o_w_valid;
   logic             i_w_ready;
   logic             o_w_lt;
   logic             o_w_gt;
   logic             o_w_eq;
   logic             o_w_busy;

   modport master (
      output i_w_valid, i_w_a, i_w_b, i_w_ready,
      input  o_w_ready, o_w_valid, o_w_lt, o_w_gt, o_w_eq, o_w_busy
   );

   modport slave (
      input  i_w_valid, i_w_a, i_w_b, i_w_ready,
      output o_w_ready, o_w_valid, o_w_lt, o_w_gt, o_w_eq, o_w_busy
   );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// rtl/serial_magnitude_comparator.sv - bit-serial MSB-first unsigned magnitude comparator
// Result is held in sticky lt/gt flags; eq is implied when neither was set.
module serial_magnitude_comparator #(
   parameter int WIDTH      = 8,
   parameter int EARLY_EXIT = 1
) (
   input logic                         i_w_clk,
   input logic                         i_w_rst_n,
   serial_magnitude_comparator_if.slave cmp
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] sh_a;
   logic [WIDTH-1:0] sh_b;
   logic [CW-1:0]    cnt;
   logic             res_lt;
   logic             res_gt;
   logic             bit_lt;
   logic             bit_gt;
   logic             found;
   logic             exit_now;

   assign bit_lt   = ~sh_a[WIDTH-1] &  sh_b[WIDTH-1];
   assign bit_gt   =  sh_a[WIDTH-1] & ~sh_b[WIDTH-1];
   assign found    = res_lt | res_gt;
   // Leave SHIFT on the last bit, or on the first difference when early exit is enabled
   assign exit_now = (cnt == '0) || ((EARLY_EXIT != 0) && !found && (bit_lt || bit_gt));

   always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
      if (!i_w_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (cmp.i_w_valid) state_nx = SHIFT;
         SHIFT:   if (exit_now)      state_nx = DONE;
         DONE:    if (cmp.i_w_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
      if (!i_w_rst_n) begin
         sh_a   <= '0;
         sh_b   <= '0;
         cnt    <= '0;
         res_lt <= 1'b0;
         res_gt <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cmp.i_w_valid) begin
                  sh_a   <= cmp.i_w_a;
                  sh_b   <= cmp.i_w_b;
                  cnt    <= CW'(WIDTH - 1);
                  res_lt <= 1'b0;
                  res_gt <= 1'b0;
               end
            end
            SHIFT: begin
               if (!found) begin
                  res_lt <= bit_lt;
                  res_gt <= bit_gt;
               end
               if (!exit_now) begin
                  sh_a <= sh_a << 1;
                  sh_b <= sh_b << 1;
                  cnt  <= cnt - CW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Result pins are gated by DONE so they stay low during and after reset
   assign cmp.o_w_ready = (state == IDLE);
   assign cmp.o_w_valid = (state == DONE);
   assign cmp.o_w_busy  = (state != IDLE);
   assign cmp.o_w_lt    = (state == DONE) &  res_lt;
   assign cmp.o_w_gt    = (state == DONE) &  res_gt;
   assign cmp.o_w_eq    = (state == DONE) & ~res_lt & ~res_gt;
endmodule
